// File: rtl/cmd_mem_pkg.sv
// Shared types and helpers for the command memory arbiter.
// Grant encoding, command width and bank-select width helpers.
package cmd_mem_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_HOST
  } gnt_t;

  function automatic int cmd_width(
    input int mem_width,
    input int mem_to_cmd
  );
    return mem_width * mem_to_cmd;
  endfunction

  function automatic int bank_sel_w(
    input int mem_to_cmd
  );
    return (mem_to_cmd > 1) ? $clog2(mem_to_cmd) : 1;
  endfunction

endpackage

// File: rtl/cmd_mem_rd_pipe.sv
// Read-latency tracker: valid shift register, DEPTH stages deep.
// Ports: clk, rst_n (async clear), in_valid (issue), out_valid (return).
module cmd_mem_rd_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      v <= {v[DEPTH-2:0], in_valid};
    end
  end

  assign out_valid = v[DEPTH-1];

endmodule

// File: rtl/cmd_mem_arbiter.sv
// Single-port arbiter for banked command memory: wide fetch vs host write.
// Ports: fetch_* / cmd_* (core), host_* (loader), mem_* (banks).
// Optional CMD_MEM_ARBITER_STATS_EN adds stat_*_cnt counters.
module cmd_mem_arbiter
  import cmd_mem_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_TO_CMD     = 4,
  parameter int READ_LATENCY   = 2,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic clk,
  input  logic rst_n,

  input  logic                      fetch_req,
  input  logic [CMD_ADDR_WIDTH-1:0] fetch_addr,
  output logic                      fetch_ready,
  output logic                      cmd_valid,
  output logic [cmd_width(MEM_WIDTH, MEM_TO_CMD)-1:0] cmd_data,

  input  logic host_wr_req,
  input  logic [CMD_ADDR_WIDTH+bank_sel_w(MEM_TO_CMD)-1:0] host_wr_addr,
  input  logic [MEM_WIDTH-1:0]      host_wr_data,
  output logic                      host_wr_ack,
  input  logic                      host_lock,

  output logic [CMD_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_TO_CMD-1:0]     mem_wen,
  output logic [MEM_WIDTH-1:0]      mem_wdata,
  input  logic [cmd_width(MEM_WIDTH, MEM_TO_CMD)-1:0] mem_rdata
`ifdef CMD_MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_host_cnt,
  output logic [31:0] stat_conflict_cnt
`endif
);

  localparam int BW = bank_sel_w(MEM_TO_CMD);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  gnt_t                      gnt;
  logic [SW-1:0]             starve_cnt;
  logic [BW-1:0]             wr_bank;
  logic [CMD_ADDR_WIDTH-1:0] wr_cmd;

  assign wr_bank = host_wr_addr[BW-1:0];
  assign wr_cmd  = host_wr_addr[BW +: CMD_ADDR_WIDTH];

  // Reset is folded in so the comb acks read 0 while rst_n is low.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_n) begin
      gnt = GNT_NONE;
    end else if (host_lock) begin
      gnt = host_wr_req ? GNT_HOST : GNT_NONE;
    end else if (host_wr_req && starve_cnt == SLIM) begin
      gnt = GNT_HOST;
    end else if (fetch_req) begin
      gnt = GNT_FETCH;
    end else if (host_wr_req) begin
      gnt = GNT_HOST;
    end
  end

  assign fetch_ready = (gnt == GNT_FETCH);
  assign host_wr_ack = (gnt == GNT_HOST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!host_wr_req || gnt == GNT_HOST) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SLIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wen   <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (gnt)
        GNT_FETCH: begin
          mem_addr <= fetch_addr;
          mem_wen  <= '0;
        end
        GNT_HOST: begin
          mem_addr  <= wr_cmd;
          mem_wen   <= MEM_TO_CMD'(1) << wr_bank;
          mem_wdata <= host_wr_data;
        end
        default: begin
          mem_wen <= '0;
        end
      endcase
    end
  end

  // One stage for the mem_addr register plus READ_LATENCY in the banks.
  cmd_mem_rd_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (gnt == GNT_FETCH),
    .out_valid (cmd_valid)
  );

  assign cmd_data = mem_rdata;

`ifdef CMD_MEM_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetch_cnt    <= '0;
      stat_host_cnt     <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (gnt == GNT_FETCH && stat_fetch_cnt != '1)
        stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      if (gnt == GNT_HOST && stat_host_cnt != '1)
        stat_host_cnt <= stat_host_cnt + 32'd1;
      if (fetch_req && host_wr_req && stat_conflict_cnt != '1)
        stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cmd_mem_arbiter.md
Name: cmd_mem_arbiter

Overview:
Single-port access controller for the banked command memory: MEM_TO_CMD parallel banks of MEM_WIDTH bits share one CMD_ADDR_WIDTH address.
- Arbitrates one memory operation per cycle between two requesters:
  - processor instruction fetch: wide read of one full command;
  - host program loader: narrow write of one bank word.
- Tracks read latency and returns assembled commands with a valid strobe.
- Sits between the processor core's instr_ptr fetch logic and the command memory banks.

Parameters:
CMD_ADDR_WIDTH, 8, command address width (shared by all banks)
MEM_WIDTH, 32, bank word width
MEM_TO_CMD, 4, number of banks per command; power of two, >=2
READ_LATENCY, 2, memory read latency in cycles from mem_addr to mem_rdata; legal range 1..4
STARVE_LIMIT, 8, consecutive host denials before host is forced to win; >=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request
fetch_addr  in  CMD_ADDR_WIDTH  command address to fetch
fetch_ready  out  1  fetch accepted this cycle (comb.)
cmd_valid  out  1  cmd_data valid this cycle
cmd_data  out  MEM_WIDTH*MEM_TO_CMD  assembled command; bank i at [MEM_WIDTH*i +: MEM_WIDTH]
host_wr_req  in  1  host write request; held until ack
host_wr_addr  in  CMD_ADDR_WIDTH+log2(MEM_TO_CMD)  word address; low bits = bank, high bits = command address
host_wr_data  in  MEM_WIDTH  write data
host_wr_ack  out  1  host write accepted this cycle (comb.)
host_lock  in  1  loader owns memory; fetches blocked
mem_addr  out  CMD_ADDR_WIDTH  registered shared bank address
mem_wen  out  MEM_TO_CMD  registered one-hot bank write enable
mem_wdata  out  MEM_WIDTH  registered write data, broadcast to all banks
mem_rdata  in  MEM_WIDTH*MEM_TO_CMD  concatenated bank read data

Behaviour:
- Reset values: fetch_ready=0, host_wr_ack=0, cmd_valid=0, mem_addr=0, mem_wen=0, mem_wdata=0, starve counter=0, read pipeline cleared.
- Grant, decided combinationally each cycle (GNT_NONE/GNT_FETCH/GNT_HOST):
  - host_lock=1: host wins whenever requesting; fetch_ready=0.
  - else if starve counter == STARVE_LIMIT and host_wr_req: host wins.
  - else if fetch_req: fetch wins.
  - else if host_wr_req: host wins.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) each cycle host_wr_req=1 and not granted;
  - clears on host grant or when host_wr_req=0.
- Fetch timing, accepted at edge ending cycle T:
  - mem_addr=fetch_addr and mem_wen=0 in cycle T+1;
  - cmd_valid=1 in cycle T+1+READ_LATENCY, with cmd_data=mem_rdata passed through unregistered;
  - back-to-back fetches are pipelined, one per cycle, returned in order.
- Host write accepted at cycle T: in cycle T+1, mem_addr=host_wr_addr high bits, mem_wen=one-hot(low bits), mem_wdata=host_wr_data.
- Idle cycle (GNT_NONE): mem_wen=0; mem_addr holds its last value.
- Ordering: operations reach memory in grant order. A fetch granted after a write to the same command returns the new data; no forwarding logic is needed.
- Read-pipeline valid shift register is READ_LATENCY+1 deep and is unaffected by interleaved writes.
- rst_n asserted mid-operation: in-flight reads are dropped (no cmd_valid after release), any pending write is not issued, outputs return to reset values immediately.

Optional Feature:
- Macro: CMD_MEM_ARBITER_STATS_EN.
- When defined, adds three outputs, each 32-bit and saturating, cleared by reset:
  - stat_fetch_cnt: granted fetches;
  - stat_host_cnt: granted writes;
  - stat_conflict_cnt: cycles with fetch_req and host_wr_req both high.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package cmd_mem_pkg holds:
  - grant enum typedef gnt_t {GNT_NONE, GNT_FETCH, GNT_HOST};
  - function cmd_width(MEM_WIDTH, MEM_TO_CMD);
  - bank-select width constant helper.
- One sub-module, cmd_mem_rd_pipe: parameterised valid shift register, depth READ_LATENCY+1, with async active-low clear.

Test Plan:
1. Reset, then fetch_req=1 with fetch_addr=0x05 for one cycle, READ_LATENCY=2 -> mem_addr=0x05 with mem_wen=0 in T+1; cmd_valid exactly one cycle at T+3 carrying bank contents at 0x05.
2. Fetches to 0x10,0x11,0x12 on consecutive cycles -> three consecutive cmd_valid pulses in order, no bubbles.
3. host_wr_req with addr=0x0E3 (cmd 0x38, bank 3), data=0xDEADBEEF, no fetch -> ack at T; mem_wen=4'b1000, mem_addr=0x38, mem_wdata=0xDEADBEEF at T+1.
4. fetch_req held high continuously, host_wr_req high, STARVE_LIMIT=8 -> host denied 8 cycles, acked on 9th, fetch_ready=0 that cycle, then counter reads 0.
5. host_lock=1 with both requesters active -> every host write acked, fetch_ready stays 0; releasing lock resumes fetches the next cycle.
6. Fetch issued, rst_n pulsed low at T+1 -> no cmd_valid afterwards, all outputs at reset values during reset; write to 0x20 then fetch 0x20 returns written word.
